vga_pattern_sequencer: RTL
==========================

// Module: vga_pattern_sequencer
// PURPOSE
//  Owns 640x480@60 VGA timing and sequences the on-screen test pattern.
//  Generates the pixel/line counters, syncs and display-enable, and selects the active pattern mode.
//  Mode selection is automatic (every FRAMES_PER_MODE frames) or manual (next_i); changes apply only at frame start.
//  Drives the RGB output directly, blanked outside the active area. Sits between the pixel-clock enable and the DAC/pins.
// PARAMETERS
//  H_ACTIVE         640  visible pixels per line
//  H_FP             16   horizontal front porch (pixels)
//  H_SYNC           96   hsync pulse width (pixels)
//  H_BP             48   horizontal back porch; line total 800
//  V_ACTIVE         480  visible lines per frame
//  V_FP             10   vertical front porch (lines)
//  V_SYNC           2    vsync pulse width (lines)
//  V_BP             33   vertical back porch; frame total 525
//  FRAMES_PER_MODE  60   frames per mode in auto mode (>=1)
//  NUM_MODES        4    number of pattern modes (2..4)
// PORTS
//  clk_i           in   1   system clock
//  rst_i           in   1   synchronous reset, active-high
//  pix_en_i        in   1   pixel strobe (25 MHz rate); all state advances only when high
//  auto_i          in   1   1 = auto-cycle modes, 0 = manual
//  next_i          in   1   advance-mode request (level, sampled on pix_en_i)
//  hsync_o         out  1   horizontal sync, active-low
//  vsync_o         out  1   vertical sync, active-low
//  de_o            out  1   display enable (active area)
//  column_o        out  10  active column 0..639, 0 when de_o=0
//  row_o           out  9   active row 0..479, 0 when de_o=0
//  frame_start_o   out  1   high for one pixel when outputs show pixel (0,0)
//  mode_o          out  2   current pattern mode
//  rgb_o           out  3   {R,G,B}; 3'b000 when de_o=0
// BEHAVIOUR
//  Reset: h=v=0, mode 0, frame count 0, pending clear; hsync_o=vsync_o=1; de_o=0; rgb_o/row_o/column_o/mode_o=0; frame_start_o=0.
//  Counters h (0..799) and v (0..524) are the next pixel to emit. On each pix_en_i: register all outputs from (h,v), then increment.
//    h wraps 799->0 and increments v; v wraps 524->0. All outputs mutually aligned; no activity when pix_en_i=0 (outputs hold).
//  hsync_o=0 iff 656<=h<752; vsync_o=0 iff 490<=v<492 (derived from parameters); de_o=(h<640)&&(v<480).
//  Mode FSM: RUN -> PEND on next_i=1 (manual or auto) or auto frame count reaching FRAMES_PER_MODE-1 at the end of a frame.
//    PEND -> RUN at (h,v)=(0,0): mode <= (mode==NUM_MODES-1)?0:mode+1; frame count <= 0.
//    In PEND, further next_i is ignored: one advance per frame max. Auto expiry and next_i together = one advance.
//    auto_i is sampled only at (0,0). Manual mode: the frame count is held at 0.
//  mode_o and the new pattern take effect on the same pixel where frame_start_o=1; never mid-frame.
//  Patterns (x=column, y=row; in active area):
//    0: solid BLUE 3'b001
//    1: RED 3'b100 for 213<=x<426, GREEN 3'b010 elsewhere
//    2: bars: rgb = x[8:6] ^ {3{x[9]}}
//    3: checker: (x[5]^y[5]) ? 3'b111 : 3'b000
//  Reset mid-frame: everything returns to its reset value next clock. The first pix_en_i after release emits pixel (0,0) of mode 0.
// TESTING
//  Reset, 800*525 pix_en: first output (0,0) de_o=1 rgb_o=001 frame_start_o=1; exactly one frame_start_o per 420000 strobes.
//  Line timing: hsync_o low for exactly 96 strobes starting at column count 656; vsync_o low for 2 lines at v=490; de_o low outside 640x480.
//  Manual, next_i pulse at v=100: mode_o stays 0 until next frame_start_o, then becomes 1; pixel x=300 -> 100, x=10 -> 010.
//  Three next_i pulses in one frame -> mode advances by exactly 1. Mode 3 + next -> mode 0.
//  Auto, FRAMES_PER_MODE=2: mode changes every 2 frames 0->1->2->3->0. next_i in the expiry frame -> single advance.
//  pix_en_i held low 50 clocks mid-line: outputs frozen. rst_i mid-frame -> hsync_o=1, de_o=0, mode_o=0 next clock.

Source files
------------

// File: rtl/vga_pattern_sequencer_if.sv
// vga_pattern_sequencer_if: pixel strobe, mode controls and registered video outputs
interface vga_pattern_sequencer_if;
  logic pix_en;
  logic auto_en;
  logic next_req;
  logic hsync;
  logic vsync;
  logic de;
  logic [9:0] column;
  logic [8:0] row;
  logic frame_start;
  logic [1:0] mode;
  logic [2:0] rgb;
  modport master (
    output pix_en, auto_en, next_req,
    input hsync, vsync, de, column, row, frame_start, mode, rgb
  );
  modport slave (
    input pix_en, auto_en, next_req,
    output hsync, vsync, de, column, row, frame_start, mode, rgb
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: VGA timing generator with frame-aligned test-pattern mode sequencing
module vga_pattern_sequencer #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FRAMES_PER_MODE = 60,
  parameter int NUM_MODES       = 4
) (
  input logic clk_i,
  input logic rst_i,
  vga_pattern_sequencer_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int FW = $clog2(FRAMES_PER_MODE + 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BAND_LO = 10'(H_ACTIVE / 3);
  localparam logic [9:0] BAND_HI = 10'(2 * H_ACTIVE / 3);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_MODE - 1);
  localparam logic [1:0] M_LAST = 2'(NUM_MODES - 1);
  typedef enum logic {RUN, PEND} state_t;
  state_t state, state_next;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [FW-1:0] fcnt, fcnt_next;
  logic [1:0] mode, mode_next;
  logic auto_q, auto_next, origin, last, active;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] rgb;
  assign origin = h == '0 && v == '0;
  assign last = h == H_LAST && v == V_LAST;
  assign active = h < H_ACT && v < V_ACT;
  assign x = 10'(h);
  assign y = 9'(v);
  assign bus.mode = mode;
  // A pending advance lands on the first pixel of the next frame; later requests in that frame are dropped
  always_comb begin
    state_next = state;
    mode_next = mode;
    auto_next = origin ? bus.auto_en : auto_q;
    fcnt_next = !auto_next ? '0 : last ? fcnt + 1'b1 : fcnt;
    if (state == PEND && origin) begin
      state_next = RUN;
      mode_next = mode == M_LAST ? 2'd0 : mode + 2'd1;
      fcnt_next = '0;
    end else if (bus.next_req || (auto_next && last && fcnt == F_LAST)) begin
      state_next = PEND;
    end
  end
  // Pattern uses the post-advance mode so the switch coincides with frame_start
  assign rgb = mode_next == 2'd0 ? 3'b001 :
               mode_next == 2'd1 ? ((x >= BAND_LO && x < BAND_HI) ? 3'b100 : 3'b010) :
               mode_next == 2'd2 ? x[8:6] ^ {3{x[9]}} :
               {3{x[5] ^ y[5]}};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      h <= '0;
      v <= '0;
      fcnt <= '0;
      mode <= '0;
      auto_q <= 1'b0;
      bus.hsync <= 1'b1;
      bus.vsync <= 1'b1;
      bus.de <= 1'b0;
      bus.column <= '0;
      bus.row <= '0;
      bus.frame_start <= 1'b0;
      bus.rgb <= '0;
    end else if (bus.pix_en) begin
      state <= state_next;
      mode <= mode_next;
      fcnt <= fcnt_next;
      auto_q <= auto_next;
      h <= h == H_LAST ? '0 : h + 1'b1;
      if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
      bus.hsync <= !(h >= HS_BEGIN && h < HS_END);
      bus.vsync <= !(v >= VS_BEGIN && v < VS_END);
      bus.de <= active;
      bus.column <= active ? x : '0;
      bus.row <= active ? y : '0;
      bus.frame_start <= origin;
      bus.rgb <= active ? rgb : '0;
    end
  end
endmodule
